// File: rtl/vram_port_arbiter.sv
// Arbitrates one single-port VRAM between the AXI register bus and the video character fetch.
// Optional starvation guard for bus requests: define VRAM_ARB_STARVE_GUARD_EN.
module vram_port_arbiter #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    S_AXI_ACLK,
    input  logic                    S_AXI_ARESET,
    input  logic                    BUS_REQ,
    input  logic                    BUS_WE,
    input  logic [ADDR_WIDTH-1:0]   BUS_ADDR,
    input  logic [DATA_WIDTH-1:0]   BUS_WDATA,
    input  logic [DATA_WIDTH/8-1:0] BUS_WSTRB,
    output logic                    BUS_ACK,
    output logic [DATA_WIDTH-1:0]   BUS_RDATA,
    input  logic                    VID_REQ,
    input  logic [ADDR_WIDTH-1:0]   VID_ADDR,
    output logic                    VID_ACK,
    output logic [DATA_WIDTH-1:0]   VID_RDATA,
    output logic                    MEM_EN,
    output logic [DATA_WIDTH/8-1:0] MEM_WE,
    output logic [ADDR_WIDTH-1:0]   MEM_ADDR,
    output logic [DATA_WIDTH-1:0]   MEM_WDATA,
    input  logic [DATA_WIDTH-1:0]   MEM_RDATA
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    if (DATA_WIDTH == 0 || DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("DATA_WIDTH must be a non-zero multiple of 8");
    end
    if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
        $error("STARVE_LIMIT must be in 1..15");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e                  state_q, state_d;
    logic                    owner_bus_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [StrbWidth-1:0]    wstrb_q;
    logic [DATA_WIDTH-1:0]   bus_rdata_q;
    logic [DATA_WIDTH-1:0]   vid_rdata_q;
    logic                    grant_bus;
    logic                    grant_any;
    logic                    issue_active;
    logic                    resp_active;

    assign grant_any = BUS_REQ || VID_REQ;

`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;

    always_comb begin
        grant_bus = BUS_REQ && (!VID_REQ || starve_q == StarveMax);
        starve_d  = starve_q;
        if (state_q == StIdle) begin
            if (!BUS_REQ || grant_bus) begin
                starve_d = '0;
            end else if (starve_q != StarveMax) begin
                // Bus waiting and video won this slot.
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign grant_bus = BUS_REQ && !VID_REQ;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_any) state_d = StIssue;
            StIssue: state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q     <= StIdle;
            owner_bus_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            bus_rdata_q <= '0;
            vid_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && grant_any) begin
                owner_bus_q <= grant_bus;
                we_q        <= grant_bus && BUS_WE;
                addr_q      <= grant_bus ? BUS_ADDR : VID_ADDR;
                if (grant_bus) begin
                    wdata_q <= BUS_WDATA;
                    wstrb_q <= BUS_WSTRB;
                end
            end
            if (state_q == StResp && !we_q) begin
                if (owner_bus_q) begin
                    bus_rdata_q <= MEM_RDATA;
                end else begin
                    vid_rdata_q <= MEM_RDATA;
                end
            end
        end
    end

    // Reset gates the strobes so an access in flight never half-completes.
    assign issue_active = (state_q == StIssue) && !S_AXI_ARESET;
    assign resp_active  = (state_q == StResp) && !S_AXI_ARESET;

    assign MEM_EN    = issue_active;
    assign MEM_WE    = (issue_active && we_q) ? wstrb_q : '0;
    assign MEM_ADDR  = addr_q;
    assign MEM_WDATA = wdata_q;

    assign BUS_ACK = resp_active && owner_bus_q;
    assign VID_ACK = resp_active && !owner_bus_q;

    // Read data bypasses the holding register so it is valid during the ACK cycle.
    assign BUS_RDATA = (BUS_ACK && !we_q) ? MEM_RDATA : bus_rdata_q;
    assign VID_RDATA = VID_ACK ? MEM_RDATA : vid_rdata_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed scoreboard bench for vram_port_arbiter with a behavioural 1-cycle-latency VRAM.
// Follows VRAM_ARB_STARVE_GUARD_EN to pick the expected grant pattern under contention.
module tb_vram_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int SL = 4;
    localparam int SW = DW / 8;
`ifdef VRAM_ARB_STARVE_GUARD_EN
    localparam int Grants = 25;
`else
    localparam int Grants = 20;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          bus_req, bus_we, bus_ack, vid_req, vid_ack, mem_en;
    logic [AW-1:0] bus_addr, vid_addr, mem_addr;
    logic [DW-1:0] bus_wdata, bus_rdata, vid_rdata, mem_wdata, mem_rdata;
    logic [SW-1:0] bus_wstrb, mem_we;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bus_q[$];
    logic [DW-1:0] vid_q[$];
    logic [DW-1:0] ref_mem [1<<AW];
    logic [DW-1:0] mem [1<<AW];
    logic          mem_written [1<<AW];
    logic [DW-1:0] last_bus_rd;

    always #5 clk = ~clk;

    vram_port_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(SL)
    ) dut (
        .S_AXI_ACLK  (clk),
        .S_AXI_ARESET(rst),
        .BUS_REQ     (bus_req),
        .BUS_WE      (bus_we),
        .BUS_ADDR    (bus_addr),
        .BUS_WDATA   (bus_wdata),
        .BUS_WSTRB   (bus_wstrb),
        .BUS_ACK     (bus_ack),
        .BUS_RDATA   (bus_rdata),
        .VID_REQ     (vid_req),
        .VID_ADDR    (vid_addr),
        .VID_ACK     (vid_ack),
        .VID_RDATA   (vid_rdata),
        .MEM_EN      (mem_en),
        .MEM_WE      (mem_we),
        .MEM_ADDR    (mem_addr),
        .MEM_WDATA   (mem_wdata),
        .MEM_RDATA   (mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return 32'h9E37_79B9 * ({22'd0, a} + 32'd1);
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [SW-1:0] ws);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < SW; b++) if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] cur_word(input logic [AW-1:0] a);
        return (mem_written[a] === 1'b1) ? mem[a] : init_val(a);
    endfunction

    // VRAM model: read-first, data valid the cycle after an enabled access.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= cur_word(mem_addr);
            if (mem_we != '0) begin
                mem[mem_addr]         <= merge(cur_word(mem_addr), mem_wdata, mem_we);
                mem_written[mem_addr] <= 1'b1;
            end
        end
    end

    function automatic bit exp_bus_grant(input int g);
`ifdef VRAM_ARB_STARVE_GUARD_EN
        return (g % (SL + 1)) == SL;
`else
        return (g < 0);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_bus(input string tag);
        check("bus_rd_pending", 64'(bus_q.size() != 0), 64'd1);
        if (bus_q.size() != 0) begin
            last_bus_rd = bus_q.pop_front();
            check(tag, bus_rdata, last_bus_rd);
        end
    endtask

    task automatic pop_vid(input string tag);
        logic [DW-1:0] e;
        check("vid_rd_pending", 64'(vid_q.size() != 0), 64'd1);
        if (vid_q.size() != 0) begin
            e = vid_q.pop_front();
            check(tag, vid_rdata, e);
        end
    endtask

    // Entered and left at #1 after a rising edge with the arbiter in IDLE.
    task automatic bus_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [SW-1:0] ws);
        bus_req = 1'b1; bus_we = we; bus_addr = a; bus_wdata = wd; bus_wstrb = ws;
        if (we) ref_mem[a] = merge(ref_mem[a], wd, ws);
        else    bus_q.push_back(ref_mem[a]);
        @(negedge clk);
        check("idle_no_en", mem_en, 0);
        @(negedge clk);
        check("issue_en", mem_en, 1);
        check("issue_we", mem_we, we ? ws : '0);
        check("issue_addr", mem_addr, a);
        if (we) check("issue_wdata", mem_wdata, wd);
        check("issue_no_ack", bus_ack, 0);
        @(negedge clk);
        check("resp_bus_ack", bus_ack, 1);
        check("resp_no_vid_ack", vid_ack, 0);
        check("resp_en_low", mem_en, 0);
        if (!we) pop_bus("bus_rdata");
        else     check("write_keeps_rdata", bus_rdata, last_bus_rd);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(negedge clk);
        check("bus_ack_one_cycle", bus_ack, 0);
        check("bus_rdata_held", bus_rdata, last_bus_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int vid_a, bus_a, vid_acks, bus_acks, acks;
        bit saw_bus, saw_vid, slot, got;

        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(AW'(i));
        last_bus_rd = '0;
        rst = 1'b1; bus_req = 0; bus_we = 0; bus_addr = '0; bus_wdata = '0; bus_wstrb = '0;
        vid_req = 0; vid_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_bus_ack", bus_ack, 0);
        check("rst_vid_ack", vid_ack, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_bus_rdata", bus_rdata, 0);
        check("rst_vid_rdata", vid_rdata, 0);
        @(posedge clk); #1;

        // Full write then read-back
        bus_access(1'b1, 10'h12, 32'hDEAD_BEEF, 4'hF);
        bus_access(1'b0, 10'h12, '0, '0);
        check("readback_deadbeef", bus_rdata, 32'hDEAD_BEEF);

        // Partial and empty strobes
        bus_access(1'b1, 10'h20, 32'h1122_3344, 4'hF);
        bus_access(1'b1, 10'h20, 32'h0000_00AA, 4'h1);
        bus_access(1'b0, 10'h20, '0, '0);
        check("partial_strobe", bus_rdata, 32'h1122_33AA);
        bus_access(1'b1, 10'h20, 32'hFFFF_FFFF, 4'h0);
        bus_access(1'b0, 10'h20, '0, '0);
        check("zero_strobe", bus_rdata, 32'h1122_33AA);

        // Back-to-back video fetches: ACK at cycles 2, 5, 8
        vid_a = 'h40; acks = 0;
        vid_req = 1'b1; vid_addr = AW'(vid_a); vid_q.push_back(ref_mem[vid_a]);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            check("b2b_vid_ack", vid_ack, (c % 3) == 2);
            check("b2b_no_bus_ack", bus_ack, 0);
            saw_vid = vid_ack;
            if (saw_vid) begin pop_vid("b2b_vid_rdata"); acks++; end
            @(posedge clk); #1;
            if (saw_vid && acks < 3) begin
                vid_a++; vid_addr = AW'(vid_a); vid_q.push_back(ref_mem[vid_a]);
            end else if (saw_vid) begin
                vid_req = 1'b0;
            end
        end
        check("b2b_vid_count", acks, 3);

        // Contention: both requesters held continuously
        vid_a = 'h100; bus_a = 'h200; vid_acks = 0; bus_acks = 0;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = AW'(bus_a); bus_q.push_back(ref_mem[bus_a]);
        vid_req = 1'b1; vid_addr = AW'(vid_a); vid_q.push_back(ref_mem[vid_a]);
        for (int c = 0; c < 3 * Grants; c++) begin
            @(negedge clk);
            slot = (c % 3) == 2;
            check("contend_bus_ack", bus_ack, slot && exp_bus_grant(c / 3));
            check("contend_vid_ack", vid_ack, slot && !exp_bus_grant(c / 3));
            saw_bus = bus_ack; saw_vid = vid_ack;
            if (saw_vid) begin pop_vid("contend_vid_rdata"); vid_acks++; end
            if (saw_bus) begin pop_bus("contend_bus_rdata"); bus_acks++; end
            @(posedge clk); #1;
            if (saw_vid) begin
                vid_a++; vid_addr = AW'(vid_a); vid_q.push_back(ref_mem[vid_a]);
            end
            if (saw_bus) begin
                bus_a++; bus_addr = AW'(bus_a); bus_q.push_back(ref_mem[bus_a]);
            end
        end
        check("contend_vid_count", vid_acks, 20);
        check("contend_bus_count", bus_acks, Grants - 20);
        // Video backs off; the waiting bus read must then complete.
        vid_req = 1'b0;
        void'(vid_q.pop_back());
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            check("release_no_vid_ack", vid_ack, 0);
            if (bus_ack) begin got = 1'b1; pop_bus("release_bus_rdata"); end
        end
        check("release_bus_ack_seen", got, 1);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(posedge clk); #1;

        // Reset during ISSUE of a bus write aborts it
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = 10'h05; bus_wdata = 32'hCAFE_F00D;
        bus_wstrb = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort_mem_en", mem_en, 0);
        check("abort_mem_we", mem_we, 0);
        check("abort_bus_ack", bus_ack, 0);
        @(posedge clk); #1;
        rst = 1'b0; bus_req = 1'b0;
        @(negedge clk);
        check("abort_no_late_ack", bus_ack, 0);
        check("abort_rdata_cleared", bus_rdata, 0);
        last_bus_rd = '0;
        @(posedge clk); #1;
        bus_access(1'b0, 10'h05, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
